seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multicycle signed 32-bit integer divider. It is the responder to the CPU's initDiv handshake.
- The CPU datapath loads operands from the A/B registers and pulses start. The block runs a restoring division, one quotient bit per cycle.
- The block returns quotient (to the LO mux) and remainder (to the HI mux), plus a done pulse and a divide-by-zero flag that feed the control FSM and cause logic.

Parameters:
- WIDTH, 32: operand/result width. Iteration count equals WIDTH.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  initDiv. Sampled only in IDLE. Level or pulse accepted.
- a_in  input  WIDTH  dividend (two's complement), sampled at the accepting edge.
- b_in  input  WIDTH  divisor (two's complement), sampled at the accepting edge.
- busy  output  1  high from the accepting edge until the edge that raises done.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse coincident with done when b_in was 0.
- hi_out  output  WIDTH  remainder.
- lo_out  output  WIDTH  quotient.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy, done, div_zero = 0; hi_out, lo_out = 0; counter and internal registers = 0.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and b_in!=0 at edge T: latch |a_in| into the dividend shift register and |b_in| into the divisor register. Record sign_q = a[31]^b[31] and sign_r = a[31]. Clear the partial remainder and the counter. busy=1. Go to RUN.
  - start=1 and b_in==0 at edge T: go to DONE. At edge T+1: done=1, div_zero=1, busy=0. hi_out/lo_out keep their previous values.
- RUN (WIDTH cycles):
  - Each edge: shift {rem,quo} left 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor (WIDTH+1-bit compare). If nonnegative, keep the difference and set quo LSB=1; else restore and set quo LSB=0.
  - Counter increments each edge. After the WIDTH-th iteration (counter==WIDTH-1), go to FIX.
- FIX (one edge, T+WIDTH+1):
  - lo_out = sign_q ? -quo : quo.
  - hi_out = sign_r ? -rem : rem.
  - Go to DONE.
- DONE (edge T+WIDTH+2): done=1 for exactly one cycle, busy=0. Next edge returns to IDLE with done=0.
- Latency: for WIDTH=32, done rises 34 edges after the accepting edge; divide-by-zero completes in 1 edge.
- Results hold stable from the FIX edge until the FIX edge of the next accepted operation.
- Semantics (MIPS div): quotient truncates toward zero; the remainder carries the dividend's sign, or is 0.
- 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no flag).
- |0x80000000| is handled as unsigned 0x80000000. The magnitude path is WIDTH bits unsigned.
- start while busy (RUN/FIX/DONE) is ignored. Operand changes during RUN have no effect.
- start held high through DONE is accepted again only once state is back in IDLE. The earliest re-acceptance is the edge after done.
- reset asserted mid-operation aborts immediately. All outputs go to reset values and no done is produced.
- done and div_zero are never high outside the DONE state. div_zero=1 implies done=1.

Test Plan:
- a=100, b=7, start 1 cycle -> busy 34 cycles; done pulse at edge T+34; lo=14, hi=2; div_zero=0.
- a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=7, b=-2 -> lo=-3, hi=1.
- Prior result lo=14/hi=2; then a=5, b=0 -> done and div_zero both high at T+1 for one cycle; lo/hi remain 14/2; busy never asserted beyond T+1.
- a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. Also a=0, b=-5 -> lo=0, hi=0.
- During RUN of 100/7: pulse start with a=9, b=3 and change a_in/b_in -> ignored, result still 14/2. Back-to-back start held high -> second op accepted on the edge after done.
- Assert reset at edge T+10 of an operation -> busy/done/div_zero/hi/lo = 0 asynchronously. After release, a fresh 20/6 gives lo=3, hi=2 at 34 edges.

Source files
------------

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the CPU datapath (master) and the
// multicycle signed divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, a_in, b_in,
        input  busy, done, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider (MIPS div semantics): one quotient bit
// per cycle on operand magnitudes, signs applied in a final fix-up cycle.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic        clk,
    input logic        reset,
    seq_divider_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;
    logic             zero_flag;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   rem_shift;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;

    // The most negative operand maps to its own bit pattern, which is the
    // correct magnitude once treated as unsigned.
    always_comb begin
        a_mag      = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
        b_mag      = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
        rem_shift  = {rem, quo[WIDTH-1]};
        trial_ge   = (rem_shift >= {1'b0, divisor});
        trial_diff = rem_shift[WIDTH-1:0] - divisor;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            quo          <= '0;
            rem          <= '0;
            divisor      <= '0;
            cnt          <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            zero_flag    <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.hi_out   <= '0;
            bus.lo_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done     <= 1'b0;
                    bus.div_zero <= 1'b0;
                    if (bus.start) begin
                        if (bus.b_in == '0) begin
                            zero_flag <= 1'b1;
                            state     <= DONE;
                        end else begin
                            quo       <= a_mag;
                            divisor   <= b_mag;
                            rem       <= '0;
                            cnt       <= '0;
                            sign_q    <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
                            sign_r    <= bus.a_in[WIDTH-1];
                            zero_flag <= 1'b0;
                            bus.busy  <= 1'b1;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    // quo doubles as the dividend shift register: its MSB
                    // feeds the remainder while quotient bits enter at the LSB.
                    rem <= trial_ge ? trial_diff : rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], trial_ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    bus.lo_out <= sign_q ? -quo : quo;
                    bus.hi_out <= sign_r ? -rem : rem;
                    state      <= DONE;
                end
                DONE: begin
                    bus.done     <= 1'b1;
                    bus.div_zero <= zero_flag;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at issue time
// and compared whenever the divider pulses done.
module tb_seq_divider;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } result_t;

    logic    clk = 1'b0;
    logic    reset = 1'b1;
    result_t exp_q[$];
    result_t mon_r;
    int      total = 0;
    int      bad = 0;
    int      cycle_count = 0;
    int      accept_cycle = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;
    logic [31:0] rnd_a;
    logic [31:0] rnd_b;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_count <= cycle_count + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    // Reference: truncating division on magnitudes, remainder follows the dividend.
    task automatic predict(input logic [31:0] a, input logic [31:0] b, output result_t r);
        logic [31:0] ua, ub, q, m;
        if (b == 32'd0) begin
            r = '{lo: last_lo, hi: last_hi, dz: 1'b1};
        end else begin
            ua = a[31] ? -a : a;
            ub = b[31] ? -b : b;
            q  = ua / ub;
            m  = ua % ub;
            r.lo = (a[31] ^ b[31]) ? -q : q;
            r.hi = a[31] ? -m : m;
            r.dz = 1'b0;
            last_lo = r.lo;
            last_hi = r.hi;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input bit hold, input bit track);
        result_t r;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        if (track) begin
            predict(a, b, r);
            exp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        accept_cycle = cycle_count;
        if (!hold) bus.start = 1'b0;
        checkOutput("busy after accept", {31'd0, bus.busy}, (b == 32'd0) ? 32'd0 : 32'd1);
    endtask

    task automatic waitDone(input int exp_lat);
        int n;
        n = 0;
        while (!bus.done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.done) begin
            checkOutput("latency", cycle_count - accept_cycle, exp_lat);
            checkOutput("busy at done", {31'd0, bus.busy}, 32'd0);
        end else begin
            checkOutput("done timeout", 32'd0, 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.div_zero && !bus.done)
            checkOutput("div_zero without done", {31'd0, bus.div_zero}, 32'd0);
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected done", {31'd0, bus.done}, 32'd0);
            end else begin
                mon_r = exp_q.pop_front();
                checkOutput("lo", bus.lo_out, mon_r.lo);
                checkOutput("hi", bus.hi_out, mon_r.hi);
                checkOutput("div_zero", {31'd0, bus.div_zero}, {31'd0, mon_r.dz});
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset div_zero", {31'd0, bus.div_zero}, 32'd0);
        checkOutput("reset hi", bus.hi_out, 32'd0);
        checkOutput("reset lo", bus.lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1);
        waitDone(34);
        applyStimulus(32'd5, 32'd0, 1'b0, 1'b1);
        waitDone(1);
        applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        waitDone(34);
        applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1);
        waitDone(34);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
        waitDone(34);
        applyStimulus(32'd0, 32'hFFFF_FFFB, 1'b0, 1'b1);
        waitDone(34);

        // start and operand changes while running must be ignored
        applyStimulus(32'd100, 32'd7, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 32'd9;
        bus.b_in  = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a_in  = 32'd123;
        bus.b_in  = 32'd0;
        waitDone(34);

        // start held high: second op accepted on the edge after done
        applyStimulus(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1);
        bus.a_in = 32'd1000;
        bus.b_in = 32'hFFFF_FFDF;
        predict(32'd1000, 32'hFFFF_FFDF, mon_r);
        exp_q.push_back(mon_r);
        waitDone(34);
        @(posedge clk);
        #1;
        accept_cycle = cycle_count;
        checkOutput("reaccept busy", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        waitDone(34);

        // asynchronous abort mid-operation
        applyStimulus(32'd20, 32'd6, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort done", {31'd0, bus.done}, 32'd0);
        checkOutput("abort div_zero", {31'd0, bus.div_zero}, 32'd0);
        checkOutput("abort hi", bus.hi_out, 32'd0);
        checkOutput("abort lo", bus.lo_out, 32'd0);
        last_lo = '0;
        last_hi = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(posedge clk);
        applyStimulus(32'd20, 32'd6, 1'b0, 1'b1);
        waitDone(34);

        for (int i = 0; i < 6; i++) begin
            rnd_a = $urandom;
            rnd_b = $urandom_range(0, 40);
            if ($urandom_range(0, 1) == 1) rnd_b = -rnd_b;
            applyStimulus(rnd_a, rnd_b, 1'b0, 1'b1);
            waitDone((rnd_b == 32'd0) ? 1 : 34);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
